// File: rtl/riscv_dmem_responder.sv
// Word-wide data-memory responder for the core's data port.
// Serves one read or write per request after LATENCY clock edges and flags out-of-window addresses.
module riscv_dmem_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] ddatout,
  output logic [31:0] ddatin,
  output logic        ready,
  output logic        busy,
  output logic        fault
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         ddatin_q, ddatin_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic                mem_we;
  logic                addr_hit;
  logic                unused_addr_bits;

  logic [31:0] mem [0:DEPTH-1];

  // Only the bits above the window size decide a hit, so nothing outside aliases in.
  assign addr_hit         = (mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign unused_addr_bits = ^mem_addr[1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    wdata_d  = wdata_q;
    ddatin_d = ddatin_q;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (en) begin
          rw_d    = rw;
          idx_d   = mem_addr[ADDR_W+1:2];
          hit_d   = addr_hit;
          wdata_d = ddatout;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // The counter reaching zero marks the access edge; en is ignored meanwhile.
        if (cnt_q == 3'd0) begin
          ready_d = 1'b1;
          fault_d = ~hit_q;
          if (rw_q) begin
            mem_we = hit_q;
          end else begin
            ddatin_d = hit_q ? mem[idx_q] : 32'h0;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      rw_q     <= 1'b0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      wdata_q  <= 32'h0;
      ddatin_q <= 32'h0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      wdata_q  <= wdata_d;
      ddatin_q <= ddatin_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  // RAM is never cleared; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ddatin = ddatin_q;
  assign ready  = ready_q;
  assign busy   = (state_q == BUSY);
  assign fault  = fault_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: directed vector table plus randomized traffic on a
// LATENCY=2 and a LATENCY=1 instance, both checked against an edge-counting reference model.
module tb_riscv_dmem_responder;

  logic        clk;
  logic        rst_v  [2];
  logic        en_v   [2];
  logic        rw_v   [2];
  logic [31:0] addr_v [2];
  logic [31:0] wdat_v [2];
  logic [31:0] dout_v [2];
  logic        rdy_v  [2];
  logic        bsy_v  [2];
  logic        flt_v  [2];

  int total = 0;
  int bad   = 0;

  riscv_dmem_responder #(.ADDR_W(10), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .rw(rw_v[0]), .mem_addr(addr_v[0]),
    .ddatout(wdat_v[0]), .ddatin(dout_v[0]), .ready(rdy_v[0]), .busy(bsy_v[0]), .fault(flt_v[0])
  );

  riscv_dmem_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .rw(rw_v[1]), .mem_addr(addr_v[1]),
    .ddatout(wdat_v[1]), .ddatin(dout_v[1]), .ready(rdy_v[1]), .busy(bsy_v[1]), .fault(flt_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a request captured at edge k completes at edge k+LAT, word RAM as an array.
  int          lat [2] = '{2, 1};
  int          edge_n = 0;
  int          cap_e [2];
  logic        m_rw  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [31:0] m_mem [2][1024];
  logic [31:0] e_dout[2];
  logic        e_rdy [2];
  logic        e_bsy [2];
  logic        e_flt [2];

  typedef struct {
    logic        rst;
    logic        en;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        bsy;
    logic        flt;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [36];

  function automatic vec_t mk(logic r, logic e, logic w, logic [31:0] a, logic [31:0] d,
                              logic xr, logic xb, logic xf, logic [31:0] xd);
    vec_t v;
    v.rst = r; v.en = e; v.rw = w; v.addr = a; v.data = d;
    v.rdy = xr; v.bsy = xb; v.flt = xf; v.dout = xd;
    return v;
  endfunction

  function automatic bit in_window(logic [31:0] a);
    return (a >> 12) == 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        cap_e[i]  = -1;
        e_dout[i] = 32'h0;
        e_rdy[i]  = 1'b0;
        e_flt[i]  = 1'b0;
      end else begin
        e_rdy[i] = 1'b0;
        e_flt[i] = 1'b0;
        if (cap_e[i] >= 0) begin
          if (edge_n == cap_e[i] + lat[i]) begin
            e_rdy[i] = 1'b1;
            e_flt[i] = !in_window(m_addr[i]);
            if (m_rw[i]) begin
              if (in_window(m_addr[i])) m_mem[i][m_addr[i][11:2]] = m_wd[i];
            end else begin
              e_dout[i] = in_window(m_addr[i]) ? m_mem[i][m_addr[i][11:2]] : 32'h0;
            end
            cap_e[i] = -1;
          end
        end else if (en_v[i]) begin
          cap_e[i]  = edge_n;
          m_rw[i]   = rw_v[i];
          m_addr[i] = addr_v[i];
          m_wd[i]   = wdat_v[i];
        end
      end
      e_bsy[i] = (cap_e[i] >= 0);
    end
  endtask

  // One clock: advance the model, let the edge pass, sample 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("model_ready%0d", i), {31'h0, rdy_v[i]}, {31'h0, e_rdy[i]});
      checkOutput($sformatf("model_busy%0d", i),  {31'h0, bsy_v[i]}, {31'h0, e_bsy[i]});
      checkOutput($sformatf("model_fault%0d", i), {31'h0, flt_v[i]}, {31'h0, e_flt[i]});
      checkOutput($sformatf("model_ddatin%0d", i), dout_v[i], e_dout[i]);
    end
    edge_n++;
  endtask

  task automatic applyStimulus(input int i, input logic r, input logic e, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    rst_v[i] = r; en_v[i] = e; rw_v[i] = w; addr_v[i] = a; wdat_v[i] = d;
  endtask

  task automatic write_word(input int i, input logic [31:0] a, input logic [31:0] d);
    applyStimulus(i, 1'b0, 1'b1, 1'b1, a, d);
    tick();
    applyStimulus(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < lat[i]; k++) tick();
  endtask

  function automatic logic [31:0] rand_addr(input int nidx);
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0)
      a = (32'($urandom_range(1, 32'hFFFFF)) << 12) | ($urandom & 32'hFFF);
    else
      a = (32'($urandom_range(0, nidx - 1)) << 2) | ($urandom & 32'h3);
    return a;
  endfunction

  task automatic random_phase(input int i, input int cycles, input int nidx);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(i, ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, rand_addr(nidx), $urandom);
      tick();
    end
    applyStimulus(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k <= lat[i]; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cap_e[i] = -1; m_rw[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0;
      e_dout[i] = '0; e_rdy[i] = 1'b0; e_bsy[i] = 1'b0; e_flt[i] = 1'b0;
      for (int w = 0; w < 1024; w++) m_mem[i][w] = 32'h0;
      applyStimulus(i, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    vecs[0]  = mk(1, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 1, 32'h0000_0040, 32'hDEADBEEF,  0, 1, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 0, 32'h0);
    vecs[4]  = mk(0, 1, 0, 32'h0000_0040, 32'h0,         0, 1, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 0, 32'hDEADBEEF);
    vecs[7]  = mk(0, 1, 1, 32'h0000_0000, 32'hA5A50000,  0, 1, 0, 32'hDEADBEEF);
    vecs[8]  = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'hDEADBEEF);
    vecs[9]  = mk(0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 0, 32'hDEADBEEF);
    vecs[10] = mk(0, 1, 1, 32'h0000_1000, 32'h12345678,  0, 1, 0, 32'hDEADBEEF);
    vecs[11] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'hDEADBEEF);
    vecs[12] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 1, 32'hDEADBEEF);
    vecs[13] = mk(0, 1, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'hDEADBEEF);
    vecs[14] = mk(0, 1, 0, 32'h0000_1000, 32'h0,         0, 1, 0, 32'hDEADBEEF);
    vecs[15] = mk(0, 1, 1, 32'h0000_0044, 32'h0,         1, 0, 0, 32'hA5A50000);
    vecs[16] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'hA5A50000);
    vecs[17] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'hA5A50000);
    vecs[18] = mk(0, 1, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'hA5A50000);
    vecs[19] = mk(0, 1, 0, 32'h0000_0040, 32'h0,         0, 1, 0, 32'hA5A50000);
    vecs[20] = mk(0, 1, 0, 32'h0000_0040, 32'h0,         1, 0, 0, 32'hA5A50000);
    vecs[21] = mk(0, 1, 0, 32'h0000_0040, 32'h0,         0, 1, 0, 32'hA5A50000);
    vecs[22] = mk(0, 1, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'hA5A50000);
    vecs[23] = mk(0, 1, 0, 32'h0000_0000, 32'h0,         1, 0, 0, 32'hDEADBEEF);
    vecs[24] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'hDEADBEEF);
    vecs[25] = mk(0, 1, 1, 32'h0000_0040, 32'h11111111,  0, 1, 0, 32'hDEADBEEF);
    vecs[26] = mk(1, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'h0);
    vecs[27] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'h0);
    vecs[28] = mk(0, 1, 0, 32'h0000_0040, 32'h0,         0, 1, 0, 32'h0);
    vecs[29] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'h0);
    vecs[30] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 0, 32'hDEADBEEF);
    vecs[31] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'hDEADBEEF);
    vecs[32] = mk(0, 1, 0, 32'h0000_1040, 32'h0,         0, 1, 0, 32'hDEADBEEF);
    vecs[33] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 1, 0, 32'hDEADBEEF);
    vecs[34] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 1, 32'h0);
    vecs[35] = mk(0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 32'h0);

    for (int v = 0; v < 36; v++) begin
      applyStimulus(0, vecs[v].rst, vecs[v].en, vecs[v].rw, vecs[v].addr, vecs[v].data);
      tick();
      checkOutput($sformatf("vec%0d_ready", v), {31'h0, rdy_v[0]}, {31'h0, vecs[v].rdy});
      checkOutput($sformatf("vec%0d_busy", v),  {31'h0, bsy_v[0]}, {31'h0, vecs[v].bsy});
      checkOutput($sformatf("vec%0d_fault", v), {31'h0, flt_v[0]}, {31'h0, vecs[v].flt});
      checkOutput($sformatf("vec%0d_ddatin", v), dout_v[0], vecs[v].dout);
    end

    for (int w = 0; w < 16; w++) write_word(0, 32'(w) << 2, $urandom);
    random_phase(0, 400, 16);

    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    write_word(1, 32'h0, 32'h0BAD_0000);
    write_word(1, 32'h4, 32'h0BAD_0004);
    write_word(1, 32'h8, 32'hCAFEF00D);
    write_word(1, 32'hC, 32'h0BAD_000C);

    applyStimulus(1, 1'b0, 1'b1, 1'b0, 32'h0000_000B, 32'h0);
    tick();
    checkOutput("lat1_capture_busy",  {31'h0, bsy_v[1]}, 32'h1);
    checkOutput("lat1_capture_ready", {31'h0, rdy_v[1]}, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("lat1_ready",  {31'h0, rdy_v[1]}, 32'h1);
    checkOutput("lat1_ddatin", dout_v[1], 32'hCAFEF00D);
    checkOutput("lat1_fault",  {31'h0, flt_v[1]}, 32'h0);

    random_phase(1, 200, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
